// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART TX core among
// several byte-stream responders, with a per-grant stall watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; pick the next requester from the rotating pointer
// ARMED     | owner granted; launch its byte once the UART is free
// WAIT_ACK  | start issued; waiting for the UART to raise busy
// WAIT_DONE | UART shifting; on completion end the packet or re-arm
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      uart_busy,
  output logic [DATA_W-1:0]         uart_data,
  output logic                      uart_start,
  output logic [ID_W-1:0]           grant_id,
  output logic                      grant_active,
  output logic                      timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LOAD   = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  wd_cnt;
  logic              last_f;

  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Rotate requests so bit 0 is the pointer's position; the lowest set bit wins.
  logic [2*NUM_REQ-1:0] rot;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        sum;
  logic [ID_W-1:0]      pick_id;

  always_comb begin
    rot = {req_valid, req_valid} >> ptr;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = ID_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_REQ_W) begin
      pick_id = sum[ID_W-1:0] - NUM_REQ_W[ID_W-1:0];
    end else begin
      pick_id = sum[ID_W-1:0];
    end
  end

  logic [ID_W-1:0] nxt_id;

  always_comb begin
    nxt_id = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      wd_cnt       <= '0;
      last_f       <= 1'b0;
      req_ready    <= '0;
      uart_data    <= '0;
      uart_start   <= 1'b0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      req_ready   <= '0;
      uart_start  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id     <= pick_id;
            grant_active <= 1'b1;
            wd_cnt       <= WD_LOAD;
            state        <= ARMED;
          end
        end
        ARMED: begin
          if (!uart_busy && req_valid[grant_id]) begin
            uart_data           <= data_arr[grant_id];
            uart_start          <= 1'b1;
            req_ready[grant_id] <= 1'b1;
            last_f              <= req_last[grant_id];
            wd_cnt              <= WD_LOAD;
            state               <= WAIT_ACK;
          end else if (wd_cnt == '0) begin
            timeout_err  <= 1'b1;
            grant_active <= 1'b0;
            ptr          <= nxt_id;
            state        <= IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (uart_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            if (last_f) begin
              grant_active <= 1'b0;
              ptr          <= nxt_id;
              state        <= IDLE;
            end else begin
              wd_cnt <= WD_LOAD;
              state  <= ARMED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a 10-cycle UART
// busy model drive two instances (long and short watchdog).
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last  = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic             uart_busy = 1'b0;

  logic [NR-1:0] m_rdy, w_rdy;
  logic [DW-1:0] m_data, w_data;
  logic          m_start, w_start, m_ga, w_ga, m_to, w_to;
  logic [1:0]    m_gid, w_gid;
  logic          sel_wd = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(1024)) dut (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(m_rdy), .uart_busy(uart_busy),
    .uart_data(m_data), .uart_start(m_start), .grant_id(m_gid),
    .grant_active(m_ga), .timeout_err(m_to)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(16)) dut_wd (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(w_rdy), .uart_busy(uart_busy),
    .uart_data(w_data), .uart_start(w_start), .grant_id(w_gid),
    .grant_active(w_ga), .timeout_err(w_to)
  );

  wire [NR-1:0] rdy_o   = sel_wd ? w_rdy   : m_rdy;
  wire [DW-1:0] data_o  = sel_wd ? w_data  : m_data;
  wire          start_o = sel_wd ? w_start : m_start;
  wire [1:0]    gid_o   = sel_wd ? w_gid   : m_gid;
  wire          ga_o    = sel_wd ? w_ga    : m_ga;
  wire          to_o    = sel_wd ? w_to    : m_to;

  always #5 CLK = ~CLK;

  logic [8:0]  rq [NR][$];
  logic [15:0] log_q [$];
  int rc [NR];
  int cyc = 0, vio = 0, t_busy_fall = 0, t_ga_fall = 0, t_to = 0, last_gap = 0;
  int ub_cnt = 0;
  logic prev_ga = 1'b0;
  logic [1:0] prev_gid = '0;
  logic mdl_busy = 1'b0, frc_busy = 1'b0, launch = 1'b0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    logic [8:0] e;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
    uart_busy = mdl_busy | frc_busy;
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    rq[i].push_back({l, b});
    apply();
  endtask

  task automatic tick();
    logic busy_prev;
    @(posedge CLK);
    #1;
    cyc++;
    if (start_o) log_q.push_back({6'd0, gid_o, data_o});
    if (to_o) t_to = cyc;
    if ($countones(rdy_o) > 1) vio++;
    if (rdy_o != '0 && rdy_o != (NR'(1) << gid_o)) vio++;
    if (start_o && uart_busy) vio++;
    if (prev_ga && ga_o && gid_o != prev_gid) vio++;
    if (prev_ga && !ga_o) t_ga_fall = cyc;
    if (!prev_ga && ga_o) last_gap = cyc - t_ga_fall;
    prev_ga = ga_o;
    prev_gid = gid_o;
    for (int i = 0; i < NR; i++) begin
      if (rdy_o[i]) begin
        rc[i]++;
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    end
    busy_prev = mdl_busy;
    if (ub_cnt > 0) begin
      ub_cnt--;
      if (ub_cnt == 0) mdl_busy = 1'b0;
    end
    if (launch) begin
      mdl_busy = 1'b1;
      ub_cnt = 10;
      launch = 1'b0;
    end
    if (start_o) launch = 1'b1;
    if (busy_prev && !mdl_busy) t_busy_fall = cyc;
    apply();
  endtask

  task automatic clear_models();
    for (int i = 0; i < NR; i++) rq[i].delete();
    mdl_busy = 1'b0;
    frc_busy = 1'b0;
    launch = 1'b0;
    ub_cnt = 0;
    apply();
  endtask

  task automatic clear_log();
    log_q.delete();
    for (int i = 0; i < NR; i++) rc[i] = 0;
    vio = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_models();
    tick();
    tick();
    rst = 1'b0;
    clear_log();
    t_to = 0;
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_idle(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      tick();
      if (q_empty() && !ga_o && !uart_busy && !launch) done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int ns;

    // Reset state
    do_reset();
    chk("rst_ready", 32'(rdy_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_start", 32'(start_o), 0);
    chk("rst_gid", 32'(gid_o), 0);
    chk("rst_ga", 32'(ga_o), 0);
    chk("rst_to", 32'(to_o), 0);

    // Single 3-byte packet from requester 2
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    run_until_idle("t1");
    chk("t1_n", log_q.size(), 3);
    chk("t1_b0", 32'(log_q[0]), 32'h02A1);
    chk("t1_b1", 32'(log_q[1]), 32'h02A2);
    chk("t1_b2", 32'(log_q[2]), 32'h02A3);
    chk("t1_rdy2", rc[2], 3);
    chk("t1_rdy_oth", rc[0] + rc[1] + rc[3], 0);
    chk("t1_drop", t_ga_fall - t_busy_fall, 1);
    chk("t1_rules", vio, 0);
    // Pointer now 3: requester 3 beats requester 0
    clear_log();
    push(0, 8'h0C, 1'b1);
    push(3, 8'h3C, 1'b1);
    run_until_idle("t1p");
    chk("t1p_first", 32'(log_q[0]), 32'h033C);
    chk("t1p_second", 32'(log_q[1]), 32'h000C);

    // Simultaneous single-byte packets, two rounds
    do_reset();
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(3, 8'h13, 1'b1);
    run_until_idle("t2a");
    chk("t2a_n", log_q.size(), 3);
    chk("t2a_0", 32'(log_q[0]), 32'h0010);
    chk("t2a_1", 32'(log_q[1]), 32'h0111);
    chk("t2a_2", 32'(log_q[2]), 32'h0313);
    chk("t2a_rules", vio, 0);
    clear_log();
    push(0, 8'h20, 1'b1);
    push(1, 8'h21, 1'b1);
    push(3, 8'h23, 1'b1);
    run_until_idle("t2b");
    chk("t2b_0", 32'(log_q[0]), 32'h0020);
    chk("t2b_1", 32'(log_q[1]), 32'h0121);
    chk("t2b_2", 32'(log_q[2]), 32'h0323);
    chk("t2b_gap", last_gap, 1);
    chk("t2b_rules", vio, 0);

    // Packet lock: requester 0 arrives after byte 1 of requester 1
    do_reset();
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b0);
    push(1, 8'h34, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (rc[1] >= 1) seen = 1'b1;
    end
    chk("t3_wait", 32'(seen), 1);
    push(0, 8'h40, 1'b1);
    run_until_idle("t3");
    chk("t3_n", log_q.size(), 5);
    chk("t3_b3", 32'(log_q[3]), 32'h0134);
    chk("t3_b4", 32'(log_q[4]), 32'h0040);
    chk("t3_rdy0", rc[0], 1);
    chk("t3_rdy1", rc[1], 4);
    chk("t3_rules", vio, 0);

    // Busy gating: UART busy for 20 cycles after grant
    do_reset();
    frc_busy = 1'b1;
    push(0, 8'h55, 1'b1);
    ns = 0;
    repeat (20) begin
      tick();
      if (start_o) ns++;
    end
    chk("t4_nostart", ns, 0);
    chk("t4_ga", 32'(ga_o), 1);
    chk("t4_gid", 32'(gid_o), 0);
    frc_busy = 1'b0;
    apply();
    tick();
    chk("t4_start", 32'(start_o), 1);
    chk("t4_data", 32'(data_o), 32'h55);
    tick();
    chk("t4_pulse", 32'(start_o), 0);
    run_until_idle("t4");
    chk("t4_n", log_q.size(), 1);
    chk("t4_rules", vio, 0);

    // Watchdog (TIMEOUT=16): requester 3 stalls after a non-last byte
    sel_wd = 1'b1;
    do_reset();
    push(3, 8'h71, 1'b0);
    tick();
    chk("t5_gid3", 32'(gid_o), 3);
    push(0, 8'h72, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (to_o) seen = 1'b1;
    end
    chk("t5_seen", 32'(seen), 1);
    chk("t5_lat", t_to - t_busy_fall, 17);
    chk("t5_ga_off", 32'(ga_o), 0);
    tick();
    chk("t5_to_pulse", 32'(to_o), 0);
    chk("t5_ga_on", 32'(ga_o), 1);
    chk("t5_gid0", 32'(gid_o), 0);
    run_until_idle("t5");
    chk("t5_b0", 32'(log_q[0]), 32'h0371);
    chk("t5_b1", 32'(log_q[1]), 32'h0072);
    sel_wd = 1'b0;

    // Reset during WAIT_DONE of byte 2 of 3
    do_reset();
    push(1, 8'h61, 1'b1);
    run_until_idle("t6a");
    push(2, 8'h81, 1'b0);
    push(2, 8'h82, 1'b0);
    push(2, 8'h83, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      if (log_q.size() == 3 && mdl_busy && ub_cnt <= 6) seen = 1'b1;
    end
    chk("t6_reach", 32'(seen), 1);
    chk("t6_pre_gid", 32'(gid_o), 2);
    chk("t6_pre_data", 32'(data_o), 32'h82);
    rst = 1'b1;
    clear_models();
    tick();
    chk("t6_ready", 32'(rdy_o), 0);
    chk("t6_data", 32'(data_o), 0);
    chk("t6_start", 32'(start_o), 0);
    chk("t6_gid", 32'(gid_o), 0);
    chk("t6_ga", 32'(ga_o), 0);
    chk("t6_to", 32'(to_o), 0);
    rst = 1'b0;
    clear_log();
    push(0, 8'h90, 1'b1);
    push(3, 8'h93, 1'b1);
    run_until_idle("t6b");
    chk("t6b_first", 32'(log_q[0]), 32'h0090);
    chk("t6b_second", 32'(log_q[1]), 32'h0393);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among several command responders (status, register read, memory dump, etc.), each presenting byte-wide response packets. It uses round-robin arbitration at packet granularity: once granted, a requester owns the UART until its last byte completes. It sits between the command handlers and the UART TX core, and drives the UART's start strobe while honouring its busy flag. A per-grant watchdog releases requesters that stall mid-packet.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT, 1024, idle cycles allowed in ARMED before grant is revoked (≥2)

Ports:
CLK  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte pending
req_data  in  NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  the pending byte is the final byte of the packet
req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
uart_busy  in  1  UART TX core is shifting
uart_data  out  DATA_W  byte to UART, stable from start until the next start
uart_start  out  1  one-cycle launch strobe to UART
grant_id  out  clog2(NUM_REQ)  current owner
grant_active  out  1  a grant is held
timeout_err  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset values: req_ready=0, uart_data=0, uart_start=0, grant_id=0, grant_active=0, timeout_err=0. State=IDLE, priority pointer=0, idle counter=0. Reset mid-packet aborts immediately; no pending strobe survives.
- States: IDLE, ARMED, WAIT_ACK, WAIT_DONE.
- IDLE: if any req_valid is set, select the first set index scanning ptr, ptr+1, ... modulo NUM_REQ. Register grant_id and set grant_active=1 on the same edge, then go to ARMED. Arbitration latency is one cycle. Requests are ignored while a grant is held.
- ARMED: idle counter counts each cycle.
  - If uart_busy=0 and req_valid[grant_id]=1: on the same edge set uart_data=req_data[grant_id], pulse uart_start and req_ready[grant_id] for exactly one cycle, latch req_last[grant_id] into last_f, clear the counter, and go to WAIT_ACK.
  - Else if the counter reaches TIMEOUT-1: pulse timeout_err, clear grant_active, set ptr=grant_id+1 (mod NUM_REQ), and go to IDLE.
- WAIT_ACK: wait for uart_busy=1, then go to WAIT_DONE. No timeout applies.
- WAIT_DONE: when uart_busy=0:
  - if last_f=1: clear grant_active, set ptr=grant_id+1 (wrap NUM_REQ-1 to 0), and go to IDLE;
  - else go to ARMED with the counter cleared.
- Throughput: back-to-back packets from different requesters incur one IDLE cycle between the last byte's completion and the next grant.
- At most one bit of req_ready is high in any cycle, and only for grant_id. uart_start never asserts while uart_busy=1.
- Protocol rule: a requester holds req_data and req_last stable while req_valid=1 until req_ready. A requester deasserting req_valid mid-packet is legal and is covered by the watchdog.
- Requester-facing behaviour is undefined if the UART never asserts busy after start; the bench must not rely on it.

Test Plan:
- Single request: req 2 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3), UART model busy for 10 cycles per byte -> three uart_start pulses carrying those bytes in order, three req_ready[2] pulses, grant_id=2 throughout, grant_active drops after the third busy falls, ptr=3.
- Simultaneous requests: reqs 0, 1 and 3 each send a 1-byte packet at the same cycle after reset -> service order 0, 1, 3. Then all re-request -> order continues 0 (ptr wrapped from 3+1), then 1, then 3.
- Packet lock: req 1 holds a 4-byte packet while req 0 asserts valid after byte 1 -> all 4 bytes of req 1 are sent before grant_id becomes 0. req_ready[0] stays low during req 1's packet.
- Busy gating: req 0 is granted while uart_busy=1 for 20 cycles -> no uart_start until the first cycle busy=0. Then exactly one start pulse.
- Watchdog: with TIMEOUT=16, req 3 sends byte 1 (not last) then drops req_valid -> timeout_err pulses 16 cycles after entering ARMED, grant_active=0, and the next pending req 0 is granted on the following cycle.
- Reset mid-packet: rst during WAIT_DONE of byte 2 of 3 -> all outputs are 0 the cycle after. After release, requester 0 has priority again.
